// File: rtl/fetcher_stride.sv
// Scanline fetcher: bus master that copies one framebuffer line per HSYNC
// into the line buffer, with pitch, per-line repeat and backpressure.
module fetcher_stride #(
    parameter int AW = 23,
    parameter int LW = 10,
    parameter int RW = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          den_i,
    input  logic [AW-1:0] fb_adr_i,
    input  logic [AW-1:0] stride_i,
    input  logic [LW-1:0] line_len_i,
    input  logic [RW-1:0] rep_i,
    input  logic          s_ready_i,
    output logic          s_we_o,
    output logic          s_last_o,
    output logic          ovr_o,
    input  logic          ack_i,
    output logic [AW-1:0] adr_o,
    output logic          cyc_o,
    output logic          stb_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [AW-1:0] line_adr_q, line_adr_d;
    logic [LW-1:0] word_cnt_q, word_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          hs_q;
    logic          ovr_q, ovr_d;
    logic          start;
    logic          beat;
    logic          last;

    assign start    = hsync_i & ~hs_q;
    assign cyc_o    = (state_q == FETCH);
    assign stb_o    = cyc_o & s_ready_i;
    assign beat     = stb_o & ack_i;
    assign last     = beat & (word_cnt_q == LW'(1));
    assign s_we_o   = beat;
    assign s_last_o = last;
    assign adr_o    = adr_q;
    assign ovr_o    = ovr_q;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        line_adr_d = line_adr_q;
        word_cnt_d = word_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        ovr_d      = ovr_q;
        if (vsync_i) begin
            state_d    = IDLE;
            adr_d      = fb_adr_i;
            line_adr_d = fb_adr_i;
            word_cnt_d = '0;
            rep_cnt_d  = '0;
            ovr_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && den_i && (line_len_i != '0)) begin
                        state_d    = FETCH;
                        adr_d      = line_adr_q;
                        word_cnt_d = line_len_i;
                    end
                end
                FETCH: begin
                    // A new line request while still busy means the
                    // previous line missed its slot.
                    if (start)
                        ovr_d = 1'b1;
                    if (beat) begin
                        adr_d      = adr_q + AW'(1);
                        word_cnt_d = word_cnt_q - LW'(1);
                    end
                    if (last) begin
                        state_d = IDLE;
                        if (rep_cnt_q == rep_i) begin
                            rep_cnt_d  = '0;
                            line_adr_d = line_adr_q + stride_i;
                        end else begin
                            rep_cnt_d  = rep_cnt_q + RW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            line_adr_q <= '0;
            word_cnt_q <= '0;
            rep_cnt_q  <= '0;
            hs_q       <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            line_adr_q <= line_adr_d;
            word_cnt_q <= word_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            hs_q       <= hsync_i;
            ovr_q      <= ovr_d;
        end
    end

endmodule
